// File: rtl/uart_pkg.sv
// Shared types and constants for the UART time-set frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOUR,
        MIN,
        SEC,
        CHK
    } state_t;

    localparam logic [7:0] MAX_HOURS         = 8'd24;
    localparam logic [7:0] MAX_MINSEC        = 8'd60;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h54;

endpackage

// File: rtl/uart_time_set_parser_if.sv
// Byte stream in from the UART receiver, validated time and error status out.
interface uart_time_set_parser_if;

    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_set_valid;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic [5:0] o_seconds;
    logic       o_frame_err;
    logic [7:0] o_err_count;

    modport master (
        output i_RX_DV, i_RX_Byte,
        input  o_set_valid, o_hours, o_minutes, o_seconds, o_frame_err, o_err_count
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte,
        output o_set_valid, o_hours, o_minutes, o_seconds, o_frame_err, o_err_count
    );

endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts idle clocks while a frame is open, restarted by each byte.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam int unsigned W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] count;

    // A byte landing on the expiry cycle suppresses the expiry.
    assign expire = active && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst || clear || !active) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_time_set_parser.sv
// Assembles 5-byte time-set frames (sync, H, M, S, XOR checksum) and emits a validated load strobe.
module uart_time_set_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_time_set_parser_if.slave  bus
);

    state_t     state;
    logic [7:0] chk;
    logic [7:0] hours_sh;
    logic [7:0] minutes_sh;
    logic [7:0] seconds_sh;
    logic       set_valid;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       frame_err;
    logic [7:0] err_count;

    logic expire;
    logic frame_ok;
    logic reject;

    uart_byte_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .active (state != IDLE),
        .clear  (bus.i_RX_DV),
        .expire (expire)
    );

    // Range check uses the full shadow byte so out-of-range values are never truncated into range.
    assign frame_ok = (bus.i_RX_Byte == chk) &&
                      (hours_sh < MAX_HOURS) &&
                      (minutes_sh < MAX_MINSEC) &&
                      (seconds_sh < MAX_MINSEC);

    assign reject = (bus.i_RX_DV && (state == CHK) && !frame_ok) || expire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            chk        <= '0;
            hours_sh   <= '0;
            minutes_sh <= '0;
            seconds_sh <= '0;
            set_valid  <= 1'b0;
            hours      <= '0;
            minutes    <= '0;
            seconds    <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            set_valid <= 1'b0;
            frame_err <= reject;
            if (reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (bus.i_RX_DV) begin
                case (state)
                    IDLE: begin
                        if (bus.i_RX_Byte == SYNC_BYTE) begin
                            chk   <= SYNC_BYTE;
                            state <= HOUR;
                        end
                    end
                    HOUR: begin
                        hours_sh <= bus.i_RX_Byte;
                        chk      <= chk ^ bus.i_RX_Byte;
                        state    <= MIN;
                    end
                    MIN: begin
                        minutes_sh <= bus.i_RX_Byte;
                        chk        <= chk ^ bus.i_RX_Byte;
                        state      <= SEC;
                    end
                    SEC: begin
                        seconds_sh <= bus.i_RX_Byte;
                        chk        <= chk ^ bus.i_RX_Byte;
                        state      <= CHK;
                    end
                    CHK: begin
                        state <= IDLE;
                        if (frame_ok) begin
                            hours     <= hours_sh[4:0];
                            minutes   <= minutes_sh[5:0];
                            seconds   <= seconds_sh[5:0];
                            set_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (expire) begin
                state <= IDLE;
            end
        end
    end

    assign bus.o_set_valid = set_valid;
    assign bus.o_hours     = hours;
    assign bus.o_minutes   = minutes;
    assign bus.o_seconds   = seconds;
    assign bus.o_frame_err = frame_err;
    assign bus.o_err_count = err_count;

endmodule

// File: tb/tb_uart_time_set_parser.sv
// Directed-vector bench for the time-set frame parser with a 100-clock inter-byte timeout.
module tb_uart_time_set_parser;

    logic clk;
    logic rst;

    uart_time_set_parser_if bus ();

    uart_time_set_parser #(
        .SYNC_BYTE    (8'h54),
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int set_pulses  = 0;
    int err_pulses  = 0;
    int both_high   = 0;

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.o_set_valid) set_pulses++;
        if (bus.o_frame_err) err_pulses++;
        if (bus.o_set_valid && bus.o_frame_err) both_high++;
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one single-cycle DV pulse; returns on the falling edge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        @(negedge clk);
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic [7:0] c);
        send_byte(8'h54);
        send_byte(h);
        send_byte(m);
        send_byte(s);
        send_byte(c);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hours"},   int'(bus.o_hours),   h);
        check_eq({tag, "_minutes"}, int'(bus.o_minutes), m);
        check_eq({tag, "_seconds"}, int'(bus.o_seconds), s);
    endtask

    initial begin
        int sp;
        int ep;
        int seen_at;

        rst           = 1'b0;
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check_time("reset", 0, 0, 0);
        check_eq("reset_set_valid", int'(bus.o_set_valid), 0);
        check_eq("reset_frame_err", int'(bus.o_frame_err), 0);
        check_eq("reset_err_count", int'(bus.o_err_count), 0);

        // Valid frame 12:30:45, strobe visible right after the checksum byte.
        send_frame(8'h0C, 8'h1E, 8'h2D, 8'h6B);
        check_eq("valid_strobe", int'(bus.o_set_valid), 1);
        check_time("valid", 12, 30, 45);
        check_eq("valid_err_count", int'(bus.o_err_count), 0);
        @(negedge clk);
        check_eq("valid_strobe_one_cycle", int'(bus.o_set_valid), 0);

        // Bad checksum: outputs held, error pulse, count 1.
        sp = set_pulses;
        send_frame(8'h0C, 8'h1E, 8'h2D, 8'h6A);
        check_eq("badchk_frame_err", int'(bus.o_frame_err), 1);
        check_eq("badchk_no_strobe", set_pulses - sp, 0);
        check_time("badchk_hold", 12, 30, 45);
        check_eq("badchk_err_count", int'(bus.o_err_count), 1);

        // Hours = 24 with correct checksum is out of range.
        sp = set_pulses;
        send_frame(8'h18, 8'h00, 8'h00, 8'h4C);
        check_eq("hours24_frame_err", int'(bus.o_frame_err), 1);
        check_eq("hours24_no_strobe", set_pulses - sp, 0);
        check_eq("hours24_err_count", int'(bus.o_err_count), 2);

        // Hours byte 0x20 must be rejected, not truncated to 0.
        send_frame(8'h20, 8'h00, 8'h00, 8'h74);
        check_eq("hours20_frame_err", int'(bus.o_frame_err), 1);
        check_time("hours20_hold", 12, 30, 45);
        check_eq("hours20_err_count", int'(bus.o_err_count), 3);

        // Timeout: error exactly 100 clocks after the last byte was sampled.
        send_byte(8'h54);
        send_byte(8'h0C);
        seen_at = -1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (bus.o_frame_err) begin
                seen_at = k;
                break;
            end
        end
        check_eq("timeout_latency", seen_at, 100);
        check_eq("timeout_err_count", int'(bus.o_err_count), 4);

        // Boundary frame 23:59:59 accepted after the timeout.
        send_frame(8'h17, 8'h3B, 8'h3B, 8'h43);
        check_eq("after_timeout_strobe", int'(bus.o_set_valid), 1);
        check_time("after_timeout", 23, 59, 59);

        // Byte arrives on the expiry cycle; sync value as checksum data is not a resync.
        ep = err_pulses;
        send_byte(8'h54);
        send_byte(8'h01);
        repeat (98) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h54);
        check_eq("expiry_byte_strobe", int'(bus.o_set_valid), 1);
        check_time("expiry_byte", 1, 2, 3);
        check_eq("expiry_byte_no_err", err_pulses - ep, 0);
        check_eq("expiry_byte_err_count", int'(bus.o_err_count), 4);

        // Leading garbage is ignored silently.
        ep = err_pulses;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h41);
        send_frame(8'h0C, 8'h1E, 8'h2D, 8'h6B);
        check_eq("garbage_strobe", int'(bus.o_set_valid), 1);
        check_time("garbage", 12, 30, 45);
        check_eq("garbage_no_err", err_pulses - ep, 0);

        // Reset mid-frame: everything cleared, no error.
        send_byte(8'h54);
        send_byte(8'h0C);
        ep = err_pulses;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_time("midreset", 0, 0, 0);
        check_eq("midreset_err_count", int'(bus.o_err_count), 0);
        check_eq("midreset_frame_err", int'(bus.o_frame_err), 0);
        @(negedge clk);
        check_eq("midreset_no_err", err_pulses - ep, 0);
        send_frame(8'h02, 8'h03, 8'h04, 8'h51);
        check_eq("midreset_idle_strobe", int'(bus.o_set_valid), 1);
        check_time("midreset_idle", 2, 3, 4);

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'h00);
            if (n == 253) check_eq("sat_254", int'(bus.o_err_count), 254);
            if (n == 254) check_eq("sat_255", int'(bus.o_err_count), 255);
        end
        check_eq("sat_hold", int'(bus.o_err_count), 255);
        check_time("sat_outputs_hold", 2, 3, 4);

        check_eq("never_both_high", both_high, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
